// File: rtl/traffic_table_uart_tx.sv
// Mode-table read-back: walks entries 0..last_idx and prints each one
// as an 8N1 ASCII line "<idx> <7 hex digits>\r\n" on txd.
module traffic_table_uart_tx #(
    parameter int BAUD_DIV = 284
) (
    input  logic        clksrc1_1,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  last_idx,
    output logic        rd_en,
    output logic [3:0]  rd_addr,
    input  logic [26:0] rd_data,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    state_t        state_q, state_d;
    logic [3:0]    entry_q, entry_d;
    logic [3:0]    last_q, last_d;
    logic [26:0]   line_q, line_d;
    logic [3:0]    byte_q, byte_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] baud_q, baud_d;

    logic [3:0]    nib;
    logic [7:0]    cur_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_ff @(posedge clksrc1_1) begin
        if (reset) begin
            state_q <= IDLE;
            entry_q <= '0;
            last_q  <= '0;
            line_q  <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            last_q  <= last_d;
            line_q  <= line_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
        end
    end

    // Digit 2 carries only the top three data bits.
    always_comb begin
        nib = entry_q;
        unique case (byte_q)
            4'd2:    nib = {1'b0, line_q[26:24]};
            4'd3:    nib = line_q[23:20];
            4'd4:    nib = line_q[19:16];
            4'd5:    nib = line_q[15:12];
            4'd6:    nib = line_q[11:8];
            4'd7:    nib = line_q[7:4];
            4'd8:    nib = line_q[3:0];
            default: nib = entry_q;
        endcase
    end

    always_comb begin
        cur_byte = hex_ascii(nib);
        unique case (byte_q)
            4'd1:    cur_byte = 8'h20;
            4'd9:    cur_byte = 8'h0D;
            4'd10:   cur_byte = 8'h0A;
            default: cur_byte = hex_ascii(nib);
        endcase
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        last_d  = last_q;
        line_d  = line_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    last_d  = last_idx;
                    entry_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = CAPTURE;
            CAPTURE: begin
                line_d  = rd_data;
                byte_d  = '0;
                bit_d   = '0;
                baud_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                baud_d = baud_q + 1'b1;
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == 4'd9) begin
                        bit_d  = '0;
                        byte_d = byte_q + 4'd1;
                        if (byte_q == 4'd10) begin
                            byte_d = '0;
                            // Compare before incrementing so entry 15 ends cleanly.
                            if (entry_q == last_q) begin
                                state_d = DONE;
                            end else begin
                                entry_d = entry_q + 4'd1;
                                state_d = FETCH;
                            end
                        end
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en   = (state_q == FETCH);
        rd_addr = rd_en ? entry_q : 4'd0;
        busy    = (state_q == FETCH) || (state_q == CAPTURE) ||
                  (state_q == SEND);
        done    = (state_q == DONE);
        txd     = 1'b1;
        if (state_q == SEND) begin
            if (bit_q == 4'd0) begin
                txd = 1'b0;
            end else if (bit_q == 4'd9) begin
                txd = 1'b1;
            end else begin
                txd = cur_byte[3'(bit_q - 4'd1)];
            end
        end
    end

endmodule

// File: tb/tb_traffic_table_uart_tx.sv
// Bench for traffic_table_uart_tx: a cycle-by-cycle expected trace is
// built from the line text and 8N1 framing rules and compared each cycle.
module tb_traffic_table_uart_tx;

    localparam int BD0 = 4;
    localparam int BD1 = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_s [2];
    logic        start_s [2];
    logic [3:0]  last_s  [2];
    logic [26:0] rdata_s [2];
    logic        rd_en_w [2];
    logic        txd_w   [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [3:0]  addr_w  [2];

    logic [26:0] mem0 [16];
    logic [26:0] mem1 [16];

    typedef struct packed {
        logic       txd;
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [3:0] addr;
    } exp_t;

    localparam exp_t IDLE_E = '{txd: 1'b1, busy: 1'b0, done: 1'b0,
                                rd_en: 1'b0, addr: 4'h0};

    exp_t q0[$];
    exp_t q1[$];

    int errs   = 0;
    int checks = 0;

    traffic_table_uart_tx #(.BAUD_DIV(BD0)) dut0 (
        .clksrc1_1(clk),
        .reset    (reset_s[0]),
        .start    (start_s[0]),
        .last_idx (last_s[0]),
        .rd_en    (rd_en_w[0]),
        .rd_addr  (addr_w[0]),
        .rd_data  (rdata_s[0]),
        .txd      (txd_w[0]),
        .busy     (busy_w[0]),
        .done     (done_w[0])
    );

    traffic_table_uart_tx #(.BAUD_DIV(BD1)) dut1 (
        .clksrc1_1(clk),
        .reset    (reset_s[1]),
        .start    (start_s[1]),
        .last_idx (last_s[1]),
        .rd_en    (rd_en_w[1]),
        .rd_addr  (addr_w[1]),
        .rd_data  (rdata_s[1]),
        .txd      (txd_w[1]),
        .busy     (busy_w[1]),
        .done     (done_w[1])
    );

    // Registered read port; junk when not strobed.
    always @(posedge clk) begin
        rdata_s[0] <= rd_en_w[0] ? mem0[addr_w[0]] : 27'h2A5A5A5;
        rdata_s[1] <= rd_en_w[1] ? mem1[addr_w[1]] : 27'h5A5A5A5;
    end

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    function automatic logic [7:0] line_byte(input int e,
                                             input logic [26:0] d,
                                             input int k);
        logic [27:0] w;
        w = {1'b0, d};
        if (k == 0)  return hexc(e);
        if (k == 1)  return 8'h20;
        if (k == 9)  return 8'h0D;
        if (k == 10) return 8'h0A;
        return hexc(int'((w >> (4 * (8 - k))) & 28'hF));
    endfunction

    task automatic push(input int inst, input exp_t e);
        if (inst == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic build(input int inst, input int last);
        int bd;
        logic [26:0] d;
        logic [7:0] b;
        logic [9:0] frame;
        bd = (inst == 0) ? BD0 : BD1;
        for (int e = 0; e <= last; e++) begin
            d = (inst == 0) ? mem0[e] : mem1[e];
            push(inst, '{txd: 1'b1, busy: 1'b1, done: 1'b0,
                         rd_en: 1'b1, addr: 4'(e)});
            push(inst, '{txd: 1'b1, busy: 1'b1, done: 1'b0,
                         rd_en: 1'b0, addr: 4'h0});
            for (int k = 0; k < 11; k++) begin
                b = line_byte(e, d, k);
                frame = {1'b1, b, 1'b0};
                for (int i = 0; i < 10; i++) begin
                    for (int c = 0; c < bd; c++) begin
                        push(inst, '{txd: frame[i], busy: 1'b1,
                                     done: 1'b0, rd_en: 1'b0,
                                     addr: 4'h0});
                    end
                end
            end
        end
        push(inst, '{txd: 1'b1, busy: 1'b0, done: 1'b1,
                     rd_en: 1'b0, addr: 4'h0});
    endtask

    task automatic cmp(input int inst);
        exp_t ex;
        exp_t act;
        act = '{txd: txd_w[inst], busy: busy_w[inst],
                done: done_w[inst], rd_en: rd_en_w[inst],
                addr: addr_w[inst]};
        ex = IDLE_E;
        if (inst == 0) begin
            if (q0.size() > 0) ex = q0.pop_front();
        end else begin
            if (q1.size() > 0) ex = q1.pop_front();
        end
        checks++;
        if (act !== ex) begin
            errs++;
            if (errs <= 20)
                $display("FAIL cycle_inst%0d t=%0t got txd/busy/done/rd_en/addr=%b want=%b",
                         inst, $time, act, ex);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cmp(0);
        cmp(1);
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errs++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic run_dump(input int inst, input int last,
                            input int ignore_at, input int reset_at,
                            input int snap_at, output int cyc,
                            output int nrd, output int nd);
        int j;
        int limit;
        bit fin;
        j = 0;
        fin = 1'b0;
        cyc = 0;
        nrd = 0;
        nd = 0;
        limit = (last + 1) * (2 + 110 * ((inst == 0) ? BD0 : BD1)) + 200;
        @(negedge clk);
        build(inst, last);
        last_s[inst] = 4'(last);
        start_s[inst] = 1'b1;
        while (!fin) begin
            @(negedge clk);
            j++;
            start_s[inst] = (j == ignore_at);
            if (j == ignore_at) last_s[inst] = 4'd3;
            if (j == snap_at) mem0[0] = 27'h7FFFFFF;
            if (rd_en_w[inst]) nrd++;
            if (done_w[inst]) begin
                nd++;
                cyc = j;
            end
            if (j == reset_at) begin
                reset_s[inst] = 1'b1;
                if (inst == 0) q0.delete();
                else q1.delete();
                @(negedge clk);
                reset_s[inst] = 1'b0;
                fin = 1'b1;
            end else if (nd > 0 && j >= cyc + 50) begin
                fin = 1'b1;
            end else if (j >= limit) begin
                fin = 1'b1;
                checks++;
                errs++;
                $display("FAIL timeout_inst%0d no done after %0d cycles",
                         inst, j);
            end
        end
    endtask

    logic [7:0] lit [11];
    int cyc, nrd, nd;

    initial begin
        reset_s = '{1'b1, 1'b1};
        start_s = '{1'b0, 1'b0};
        last_s  = '{4'd0, 4'd0};
        for (int a = 0; a < 16; a++) begin
            mem0[a] = 27'(a) * 27'h1111111;
            mem1[a] = 27'($urandom);
        end
        lit = '{8'h30, 8'h20, 8'h34, 8'h46, 8'h32, 8'h43,
                8'h38, 8'h42, 8'h32, 8'h0D, 8'h0A};

        repeat (3) @(negedge clk);
        reset_s = '{1'b0, 1'b0};
        repeat (1000) @(negedge clk);
        chk("idle_txd", int'(txd_w[0]), 1);
        chk("idle_busy", int'(busy_w[0]), 0);

        for (int k = 0; k < 11; k++)
            chk($sformatf("model_byte%0d", k),
                int'(line_byte(0, 27'h4F2C8B2, k)), int'(lit[k]));
        chk("model_digit2_trunc", int'(line_byte(9, 27'h1999999, 2)), 8'h31);
        chk("model_idx_C", int'(line_byte(12, 27'h0, 0)), 8'h43);

        // Single line; table word altered after capture.
        mem0[0] = 27'h4F2C8B2;
        run_dump(0, 0, -1, -1, 5, cyc, nrd, nd);
        chk("one_line_cycles", cyc, 443);
        chk("one_line_rd", nrd, 1);
        chk("one_line_done", nd, 1);

        // Ten lines with an ignored start and a last_idx change mid-dump.
        run_dump(0, 9, 100, -1, -1, cyc, nrd, nd);
        chk("ten_cycles", cyc, 4421);
        chk("ten_rd", nrd, 10);
        chk("ten_done", nd, 1);

        // Abort in byte 5 of line 2, then a fresh full dump.
        run_dump(0, 9, -1, 3 + 2 * 442 + 220, -1, cyc, nrd, nd);
        chk("abort_done", nd, 0);
        run_dump(0, 9, -1, -1, -1, cyc, nrd, nd);
        chk("redo_cycles", cyc, 4421);
        chk("redo_rd", nrd, 10);
        chk("redo_done", nd, 1);

        // Start coincident with reset must be dropped.
        @(negedge clk);
        reset_s[1] = 1'b1;
        start_s[1] = 1'b1;
        @(negedge clk);
        reset_s[1] = 1'b0;
        start_s[1] = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_start_busy", int'(busy_w[1]), 0);

        run_dump(1, 15, -1, -1, -1, cyc, nrd, nd);
        chk("full_cycles", cyc, 12353);
        chk("full_rd", nrd, 16);
        chk("full_done", nd, 1);

        repeat (20) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
